// File: rtl/param_seq_detector.sv
// rtl/param_seq_detector.sv - Parametrised Mealy serial-pattern detector with loadable pattern.
// Optional saturating match counter built when MATCH_CNT_EN is defined.
module param_seq_detector #(
    parameter int                 SEQ_LEN = 3,
    parameter logic [SEQ_LEN-1:0] PATTERN = 3'b101,
    parameter int                 CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               d_in,
    input  logic               d_valid,
    input  logic               overlap,
    input  logic               pat_load,
    input  logic [SEQ_LEN-1:0] pat_in,
    input  logic               cnt_clr,
    output logic               q_out,
    output logic               q_reg,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam int             FW   = $clog2(SEQ_LEN);
    localparam logic [FW-1:0]  FULL = FW'(SEQ_LEN - 1);

    logic [SEQ_LEN-1:0] pat_reg;
    logic [SEQ_LEN-2:0] hist;
    logic [FW-1:0]      fill;
    logic [SEQ_LEN-1:0] window;
    logic               match;

    // Candidate window: stored history followed by the bit arriving now.
    assign window = {hist, d_in};
    assign match  = d_valid & ~pat_load & (fill == FULL) & (window == pat_reg);
    assign q_out  = match;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_reg <= PATTERN;
            hist    <= '0;
            fill    <= '0;
        end else if (pat_load) begin
            pat_reg <= pat_in;
            hist    <= '0;
            fill    <= '0;
        end else if (d_valid) begin
            hist <= window[SEQ_LEN-2:0];
            if (match && !overlap) begin
                fill <= '0;
            end else if (fill != FULL) begin
                fill <= fill + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_reg <= 1'b0;
        end else begin
            q_reg <= match;
        end
    end

`ifdef MATCH_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_cnt <= '0;
        end else if (cnt_clr) begin
            match_cnt <= '0;
        end else if (match && (match_cnt != {CNT_W{1'b1}})) begin
            match_cnt <= match_cnt + 1'b1;
        end
    end
`else
    // Clear input kept only so the port list is identical in both builds.
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule
